// File: rtl/fetch_inst_buffer.sv
// Fetch-to-decode instruction buffer: 3-wide packed write, 3-wide show-ahead read,
// circular FIFO with flush and a sticky overflow flag.

module fib_lane #(
  parameter int W = 97
) (
  input  logic         vld,
  input  logic [W-1:0] ent,
  output logic [W-1:0] out
);
  assign out = vld ? ent : '0;
endmodule

module fetch_inst_buffer #(
  parameter int size  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [2:0]               fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [size-1:0]          instruction_i_0,
  input  logic [size-1:0]          instruction_i_1,
  input  logic [size-1:0]          instruction_i_2,
  input  logic [size-1:0]          pc_i_0,
  input  logic [size-1:0]          pc_i_1,
  input  logic [size-1:0]          pc_i_2,
  input  logic [size-1:0]          imm_i_0,
  input  logic [size-1:0]          imm_i_1,
  input  logic [size-1:0]          imm_i_2,
  input  logic                     branch_prediction_i_0,
  input  logic                     branch_prediction_i_1,
  input  logic                     branch_prediction_i_2,
  output logic [2:0]               decode_valid_o,
  input  logic [1:0]               decode_accept_i,
  output logic [size-1:0]          instruction_o_0,
  output logic [size-1:0]          instruction_o_1,
  output logic [size-1:0]          instruction_o_2,
  output logic [size-1:0]          pc_o_0,
  output logic [size-1:0]          pc_o_1,
  output logic [size-1:0]          pc_o_2,
  output logic [size-1:0]          imm_o_0,
  output logic [size-1:0]          imm_o_1,
  output logic [size-1:0]          imm_o_2,
  output logic                     branch_prediction_o_0,
  output logic                     branch_prediction_o_1,
  output logic                     branch_prediction_o_2,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [size-1:0] instr;
    logic [size-1:0] pc;
    logic [size-1:0] imm;
    logic            bp;
  } entry_t;
  localparam int EW = $bits(entry_t);

  entry_t             mem [DEPTH];
  logic [AW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic               ovf;
  logic               ready;
  entry_t [2:0]       wr_ent, rd_ent, rd_out;
  logic [2:0]         rd_vld;
  logic [1:0]         wr_off [3];
  logic [1:0]         nw, wr_cnt, avail, nr;

  assign wr_ent[0] = {instruction_i_0, pc_i_0, imm_i_0, branch_prediction_i_0};
  assign wr_ent[1] = {instruction_i_1, pc_i_1, imm_i_1, branch_prediction_i_1};
  assign wr_ent[2] = {instruction_i_2, pc_i_2, imm_i_2, branch_prediction_i_2};

  // Space check uses the registered count only; a same-edge read never opens room.
  assign ready  = (count <= CW'(DEPTH - 3));

  // Set lanes are compacted: each lane lands after the set lanes below it.
  assign wr_off[0] = 2'd0;
  assign wr_off[1] = 2'(fetch_valid_i[0]);
  assign wr_off[2] = 2'(fetch_valid_i[0]) + 2'(fetch_valid_i[1]);
  assign nw        = wr_off[2] + 2'(fetch_valid_i[2]);
  assign wr_cnt    = ready ? nw : 2'd0;

  assign avail = (count >= CW'(3)) ? 2'd3 : count[1:0];
  assign nr    = (decode_accept_i > avail) ? avail : decode_accept_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if ((|fetch_valid_i) && !ready) ovf <= 1'b1;
      tail  <= tail + AW'(wr_cnt);
      head  <= head + AW'(nr);
      count <= count + CW'(wr_cnt) - CW'(nr);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && ready) begin
      for (int k = 0; k < 3; k++)
        if (fetch_valid_i[k]) mem[tail + AW'(wr_off[k])] <= wr_ent[k];
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_lane
    assign rd_ent[k] = mem[head + AW'(k)];
    assign rd_vld[k] = ~reset & (count > CW'(k));
    fib_lane #(.W(EW)) u_lane (.vld(rd_vld[k]), .ent(rd_ent[k]), .out(rd_out[k]));
  end

  assign fetch_ready_o  = ready & ~reset;
  assign decode_valid_o = rd_vld;
  assign count_o        = count;
  assign overflow_o     = ovf;

  assign instruction_o_0       = rd_out[0].instr;
  assign instruction_o_1       = rd_out[1].instr;
  assign instruction_o_2       = rd_out[2].instr;
  assign pc_o_0                = rd_out[0].pc;
  assign pc_o_1                = rd_out[1].pc;
  assign pc_o_2                = rd_out[2].pc;
  assign imm_o_0               = rd_out[0].imm;
  assign imm_o_1               = rd_out[1].imm;
  assign imm_o_2               = rd_out[2].imm;
  assign branch_prediction_o_0 = rd_out[0].bp;
  assign branch_prediction_o_1 = rd_out[1].bp;
  assign branch_prediction_o_2 = rd_out[2].bp;
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Bench for fetch_inst_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model.

module tb_fetch_inst_buffer;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        bp;
  } ent_t;

  logic        clk = 0, reset = 0, flush = 0;
  logic [2:0]  fv = '0;
  logic [1:0]  acc = '0;
  logic [31:0] ins [3], pcs [3], imms [3];
  logic        bp [3];

  logic        fetch_ready_o, overflow_o;
  logic [2:0]  decode_valid_o;
  logic [4:0]  count_o;
  logic [31:0] instruction_o_0, instruction_o_1, instruction_o_2;
  logic [31:0] pc_o_0, pc_o_1, pc_o_2, imm_o_0, imm_o_1, imm_o_2;
  logic        branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2;
  ent_t        dout [3];

  ent_t q[$];
  bit   ovf_m;
  int   errors = 0, checks = 0;

  fetch_inst_buffer #(.size(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_valid_i(fv), .fetch_ready_o(fetch_ready_o),
    .instruction_i_0(ins[0]), .instruction_i_1(ins[1]), .instruction_i_2(ins[2]),
    .pc_i_0(pcs[0]), .pc_i_1(pcs[1]), .pc_i_2(pcs[2]),
    .imm_i_0(imms[0]), .imm_i_1(imms[1]), .imm_i_2(imms[2]),
    .branch_prediction_i_0(bp[0]), .branch_prediction_i_1(bp[1]),
    .branch_prediction_i_2(bp[2]),
    .decode_valid_o(decode_valid_o), .decode_accept_i(acc),
    .instruction_o_0(instruction_o_0), .instruction_o_1(instruction_o_1),
    .instruction_o_2(instruction_o_2),
    .pc_o_0(pc_o_0), .pc_o_1(pc_o_1), .pc_o_2(pc_o_2),
    .imm_o_0(imm_o_0), .imm_o_1(imm_o_1), .imm_o_2(imm_o_2),
    .branch_prediction_o_0(branch_prediction_o_0),
    .branch_prediction_o_1(branch_prediction_o_1),
    .branch_prediction_o_2(branch_prediction_o_2),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  assign dout[0] = {instruction_o_0, pc_o_0, imm_o_0, branch_prediction_o_0};
  assign dout[1] = {instruction_o_1, pc_o_1, imm_o_1, branch_prediction_o_1};
  assign dout[2] = {instruction_o_2, pc_o_2, imm_o_2, branch_prediction_o_2};

  always #5 clk = ~clk;

  task automatic set_lane(input int k, input logic [31:0] pc);
    pcs[k]  = pc;
    ins[k]  = pc ^ 32'h5a5a_0000 ^ 32'($urandom_range(0, 255));
    imms[k] = $urandom;
    bp[k]   = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input logic r, input logic f, input logic [2:0] v, input logic [1:0] a);
    reset = r; flush = f; fv = v; acc = a;
  endtask

  // Reference behaviour at a clock edge, from the buffer's rules.
  task automatic model_edge();
    ent_t w[$];
    int   n;
    bit   rdy;
    if (reset) begin
      q.delete(); ovf_m = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      rdy = (DEPTH - q.size()) >= 3;
      n = int'(acc);
      if (n > q.size()) n = q.size();
      for (int k = 0; k < 3; k++)
        if (fv[k]) w.push_back({ins[k], pcs[k], imms[k], bp[k]});
      if (w.size() != 0 && !rdy) ovf_m = 1;
      repeat (n) void'(q.pop_front());
      if (rdy) foreach (w[j]) q.push_back(w[j]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr3(input logic [2:0] v, input logic [1:0] a, input logic [31:0] base);
    for (int k = 0; k < 3; k++) set_lane(k, base + 32'(4 * k));
    drive(0, 0, v, a);
    cyc();
  endtask

  task automatic do_reset();
    drive(1, 0, 3'b000, 2'd0);
    cyc();
    drive(0, 0, 3'b000, 2'd0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) set_lane(k, 32'h0);
    drive(1, 0, 3'b000, 2'd0);
    #1;
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_hi got=%b exp=0", fetch_ready_o); end
    cyc();
    drive(0, 0, 3'b000, 2'd0);
    #1;
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow_o); end
    checks++; if (decode_valid_o !== 3'b000) begin errors++; $display("FAIL rst_valid got=%b exp=000", decode_valid_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", fetch_ready_o); end
    wr3(3'b111, 2'd0, 32'h0);
    checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL t1_count got=%0d exp=3", count_o); end
    checks++; if (decode_valid_o !== 3'b111) begin errors++; $display("FAIL t1_valid got=%b exp=111", decode_valid_o); end
    checks++; if (pc_o_0 !== 32'h0) begin errors++; $display("FAIL t1_pc0 got=%h exp=0", pc_o_0); end
    checks++; if (pc_o_2 !== 32'h8) begin errors++; $display("FAIL t1_pc2 got=%h exp=8", pc_o_2); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) wr3(3'b111, 2'd0, 32'h100 + 32'(12 * i));
    checks++; if (count_o !== 5'd15) begin errors++; $display("FAIL t2_count got=%0d exp=15", count_o); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL t2_ready got=%b exp=0", fetch_ready_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL t2_ovf_pre got=%b exp=0", overflow_o); end
    wr3(3'b111, 2'd0, 32'h900);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL t2_ovf got=%b exp=1", overflow_o); end
    checks++; if (count_o !== 5'd15) begin errors++; $display("FAIL t2_count_hold got=%0d exp=15", count_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) wr3(3'b111, 2'd0, 32'h100 + 32'(12 * i));
    for (int i = 0; i < 4; i++) begin drive(0, 0, 3'b000, 2'd3); cyc(); end
    drive(0, 0, 3'b000, 2'd1); cyc();
    checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL t3_pre_count got=%0d exp=2", count_o); end
    checks++; if (pc_o_1 !== 32'h138) begin errors++; $display("FAIL t3_pre_pc1 got=%h exp=138", pc_o_1); end
    wr3(3'b111, 2'd2, 32'h200);
    checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL t3_count got=%0d exp=3", count_o); end
    checks++; if (pc_o_0 !== 32'h200) begin errors++; $display("FAIL t3_pc0 got=%h exp=200", pc_o_0); end
    checks++; if (pc_o_1 !== 32'h204) begin errors++; $display("FAIL t3_pc1 got=%h exp=204", pc_o_1); end
    checks++; if (pc_o_2 !== 32'h208) begin errors++; $display("FAIL t3_pc2 got=%h exp=208", pc_o_2); end
  endtask

  task automatic test_sparse();
    do_reset();
    set_lane(0, 32'h10); set_lane(1, 32'hdead); set_lane(2, 32'h18);
    drive(0, 0, 3'b101, 2'd0);
    cyc();
    checks++; if (decode_valid_o !== 3'b011) begin errors++; $display("FAIL t4_valid got=%b exp=011", decode_valid_o); end
    checks++; if (pc_o_0 !== 32'h10) begin errors++; $display("FAIL t4_pc0 got=%h exp=10", pc_o_0); end
    checks++; if (pc_o_1 !== 32'h18) begin errors++; $display("FAIL t4_pc1 got=%h exp=18", pc_o_1); end
    checks++; if (pc_o_2 !== 32'h0) begin errors++; $display("FAIL t4_pc2 got=%h exp=0", pc_o_2); end
    checks++; if (instruction_o_1 !== ins[2]) begin errors++; $display("FAIL t4_ins1 got=%h exp=%h", instruction_o_1, ins[2]); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) wr3(3'b111, 2'd0, 32'h300 + 32'(12 * i));
    checks++; if (count_o !== 5'd9) begin errors++; $display("FAIL t5_pre_count got=%0d exp=9", count_o); end
    for (int k = 0; k < 3; k++) set_lane(k, 32'h400);
    drive(0, 1, 3'b111, 2'd3);
    cyc();
    drive(0, 0, 3'b000, 2'd0);
    #1;
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL t5_count got=%0d exp=0", count_o); end
    checks++; if (decode_valid_o !== 3'b000) begin errors++; $display("FAIL t5_valid got=%b exp=000", decode_valid_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL t5_ready got=%b exp=1", fetch_ready_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 6; i++) wr3(3'b111, 2'd0, 32'h500);
    drive(0, 1, 3'b000, 2'd0); cyc();
    drive(0, 0, 3'b000, 2'd0);
    #1;
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL t6_ovf_flush got=%b exp=1", overflow_o); end
    wr3(3'b111, 2'd0, 32'h600);
    wr3(3'b111, 2'd0, 32'h610);
    wr3(3'b100, 2'd0, 32'h620);
    checks++; if (count_o !== 5'd7) begin errors++; $display("FAIL t6_pre_count got=%0d exp=7", count_o); end
    drive(1, 0, 3'b111, 2'd1);
    #1;
    checks++; if (decode_valid_o !== 3'b000) begin errors++; $display("FAIL t6_valid_hi got=%b exp=000", decode_valid_o); end
    checks++; if (pc_o_0 !== 32'h0) begin errors++; $display("FAIL t6_pc0_hi got=%h exp=0", pc_o_0); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL t6_ready_hi got=%b exp=0", fetch_ready_o); end
    cyc();
    drive(0, 0, 3'b000, 2'd0);
    #1;
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL t6_count got=%0d exp=0", count_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL t6_ovf got=%b exp=0", overflow_o); end
    checks++; if (decode_valid_o !== 3'b000) begin errors++; $display("FAIL t6_valid got=%b exp=000", decode_valid_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int   r, sz;
      logic er;
      logic [2:0] ev;
      ent_t e;
      r = $urandom_range(0, 99);
      for (int k = 0; k < 3; k++) set_lane(k, $urandom);
      drive(r < 2, (r >= 2) && (r < 6), 3'($urandom), 2'($urandom));
      #1;
      sz = q.size();
      er = !reset && ((DEPTH - sz) >= 3);
      for (int k = 0; k < 3; k++) ev[k] = !reset && (sz > k);
      checks++; if (fetch_ready_o !== er) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, fetch_ready_o, er); end
      checks++; if (decode_valid_o !== ev) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, decode_valid_o, ev); end
      checks++; if (count_o !== 5'(sz)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count_o, sz); end
      checks++; if (overflow_o !== ovf_m) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, overflow_o, ovf_m); end
      for (int k = 0; k < 3; k++) begin
        e = ev[k] ? q[k] : '0;
        checks++; if (dout[k] !== e) begin errors++; $display("FAIL rnd_lane%0d cyc=%0d got=%h exp=%h", k, i, dout[k], e); end
      end
      cyc();
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) set_lane(k, 32'h0);
    test_reset();
    test_overflow();
    test_wrap();
    test_sparse();
    test_flush();
    test_mid_reset();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
